imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time program loader; the write side of the instruction memory's write-back port.
//   Takes a framed byte stream (valid/ready, e.g. from a UART receiver).
//   Assembles little-endian 32-bit words and issues one wb_en/wb_address/wb_data write per word.
//   Holds the core (cpu_hold) while a load is in progress or after a failed load.
// PARAMETERS
//   BASE_WORD  0   word index written by the first data word
//   MAX_WORDS  21  instruction memory depth in words; larger frames are rejected
//   MAGIC      8'hA5  frame start byte
// PORTS
//   clk           input   1   system clock, all logic on posedge
//   rst           input   1   asynchronous, active-low reset (0 = reset)
//   rx_valid      input   1   rx_data valid this cycle
//   rx_data       input   8   stream byte
//   rx_ready      output  1   loader accepts byte; transfer when rx_valid & rx_ready
//   wb_en         output  1   one-cycle instruction-memory write strobe
//   wb_address    output  32  word index (not byte address) for the write
//   wb_data       output  32  assembled instruction word
//   cpu_hold      output  1   keep core stalled/in reset
//   done          output  1   one-cycle pulse, frame loaded successfully
//   error         output  1   one-cycle pulse, frame rejected
//   loaded_words  output  16  word count of last successful frame
// BEHAVIOUR
//   Frame: MAGIC, LEN_LO, LEN_HI, LEN x {B0,B1,B2,B3} (B0 = bits 7:0), [CSUM].
//   Reset (rst=0): state IDLE, rx_ready=1, wb_en=0, wb_address=0, wb_data=0,
//     cpu_hold=0, done=0, error=0, loaded_words=0, byte/word counters=0.
//   FSM states and transitions:
//   - IDLE: non-MAGIC bytes are discarded.
//     MAGIC -> LEN_LO; cpu_hold=1; checksum accumulator=0.
//   - LEN_LO, LEN_HI: capture the 16-bit LEN.
//     After LEN_HI: LEN>MAX_WORDS -> ERR; LEN==0 -> CSUM if enabled, else FIN; otherwise DATA.
//   - DATA: byte_idx counts 0..3.
//     On the accepted B3: wb_en=1 next cycle, wb_address=BASE_WORD+word_cnt, wb_data={B3,B2,B1,B0}.
//     word_cnt increments. After word LEN-1: -> CSUM if enabled, else FIN.
//   - FIN: one cycle. done=1, loaded_words=LEN, cpu_hold=0, rx_ready=0, then -> IDLE.
//   - ERR: one cycle. error=1, cpu_hold stays 1, rx_ready=0, then -> IDLE.
//     cpu_hold clears only on a later successful frame.
//   Throughput and latency:
//   - rx_ready=1 in every state except FIN and ERR, so one byte can be accepted per cycle.
//   - wb_en is a single-cycle pulse 1 clk after the 4th byte; back-to-back words give wb_en every 4 cycles.
//   - wb_address/wb_data hold their values between strobes.
//   Boundaries:
//   - rx_valid=0 mid-frame: state holds indefinitely (no timeout).
//   - MAGIC inside LEN or DATA is ordinary data and does not restart the frame.
//   - Address arithmetic is 32-bit with no wrap check; the MAX_WORDS check guarantees it stays in range.
//   - Words already written before an error are not rolled back; cpu_hold protects the core.
//   - rst asserted mid-frame: immediate return to reset values, partial word discarded.
//     cpu_hold drops to 0, so the system must re-load after reset.
// CONFIGURATION
//   IMEM_LOADER_CSUM_EN defined:
//   - Adds state CSUM after the last data word (or after LEN_HI when LEN==0).
//   - The 8-bit sum of LEN_LO, LEN_HI, all data bytes and the CSUM byte must equal 8'h00.
//   - Match -> FIN. Mismatch -> ERR.
//   IMEM_LOADER_CSUM_EN undefined:
//   - No CSUM byte is expected; the checksum logic is absent; the last word goes straight to FIN.
// TESTING
//   1. Reset, frame A5 01 00 13 05 00 00 [CSUM E7]
//      -> one wb_en, wb_address=0, wb_data=32'h00000513; done pulse; loaded_words=1; cpu_hold 1 then 0.
//   2. 3-word frame, rx_valid every cycle -> wb_en at cycles 4/8/12 after LEN_HI; addresses 0,1,2; data as sent.
//   3. Frame with LEN=22 (16 00) -> error pulse after LEN_HI, no wb_en, cpu_hold stays 1.
//      Then a valid frame -> cpu_hold=0.
//   4. Garbage 00 FF 12 before A5, and rx_valid gaps of 0-5 cycles inside a word
//      -> garbage ignored; same writes as test 1.
//   5. Drive rst=0 after B1 of word 2, then release -> no further wb_en; all outputs at reset values;
//      the next full frame loads normally.
//   6. (CSUM_EN) Test 1 with CSUM=E6 -> wb_en for the word, then error pulse, no done, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses MAGIC/LEN/data frames from a byte stream
// and issues one write per little-endian word. Optional checksum: IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int unsigned BASE_WORD = 0,
    parameter int unsigned MAX_WORDS = 21,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wb_en,
    output logic [31:0] wb_address,
    output logic [31:0] wb_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] loaded_words,
    output logic [2:0]  state_dbg
);

    // Handshake: a byte transfers on a rising edge where rx_valid & rx_ready are both 1.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_FIN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_FIN;
`endif

    state_t      state, next_state;
    logic        accept;
    logic [15:0] len_q;
    logic [15:0] hdr_len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] part_q;
    logic        last_word;

    assign accept    = rx_valid & rx_ready;
    assign hdr_len   = {rx_data, len_q[7:0]};
    assign last_word = ((word_cnt + 16'd1) == len_q);

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q;
    logic [7:0] csum_sum;

    assign csum_sum = csum_q + rx_data;

    // Running 8-bit sum of every byte after MAGIC; cleared whenever IDLE takes a byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            if (state == S_IDLE) csum_q <= 8'h00;
            else                 csum_q <= csum_sum;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept && rx_data == MAGIC) next_state = S_LEN_LO;
            S_LEN_LO: if (accept) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (32'(hdr_len) > MAX_WORDS) next_state = S_ERR;
                    else if (hdr_len == 16'd0)    next_state = AFTER_DATA;
                    else                          next_state = S_DATA;
                end
            end
            S_DATA:   if (accept && byte_idx == 2'd3 && last_word) next_state = AFTER_DATA;
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM:   if (accept) next_state = (csum_sum == 8'h00) ? S_FIN : S_ERR;
`endif
            S_FIN:    next_state = S_IDLE;
            S_ERR:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        state_dbg = state;
        case (state)
            S_FIN: begin
                rx_ready = 1'b0;
                done     = 1'b1;
            end
            S_ERR: begin
                rx_ready = 1'b0;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length capture, word assembly, write strobe and hold/loaded bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q        <= 16'd0;
            word_cnt     <= 16'd0;
            byte_idx     <= 2'd0;
            part_q       <= 24'd0;
            wb_en        <= 1'b0;
            wb_address   <= 32'd0;
            wb_data      <= 32'd0;
            cpu_hold     <= 1'b0;
            loaded_words <= 16'd0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && rx_data == MAGIC) begin
                        cpu_hold <= 1'b1;
                        word_cnt <= 16'd0;
                        byte_idx <= 2'd0;
                    end
                end
                S_LEN_LO: if (accept) len_q[7:0]  <= rx_data;
                S_LEN_HI: if (accept) len_q[15:8] <= rx_data;
                S_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wb_en      <= 1'b1;
                            wb_address <= BASE_WORD + 32'(word_cnt);
                            wb_data    <= {rx_data, part_q};
                            word_cnt   <= word_cnt + 16'd1;
                        end else begin
                            // Bytes enter at the top so B0 ends up in bits 7:0.
                            part_q <= {rx_data, part_q[23:8]};
                        end
                    end
                end
                default: ;
            endcase
            if (next_state == S_FIN && state != S_FIN) begin
                cpu_hold     <= 1'b0;
                loaded_words <= (state == S_LEN_HI) ? hdr_len : len_q;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a frame-level reference model.
// Builds with or without IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

    localparam int unsigned BASE_WORD = 0;
    localparam int unsigned MAX_WORDS = 21;
    localparam logic [7:0]  MAGIC     = 8'hA5;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wb_en;
    logic [31:0] wb_address;
    logic [31:0] wb_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] loaded_words;
    logic [2:0]  state_dbg;

    imem_loader #(
        .BASE_WORD(BASE_WORD),
        .MAX_WORDS(MAX_WORDS),
        .MAGIC(MAGIC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .wb_en(wb_en),
        .wb_address(wb_address),
        .wb_data(wb_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .loaded_words(loaded_words),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          got_cyc_q[$];
    int          acc_cyc_q[$];
    int          done_cnt, err_cnt;
    int          exp_done, exp_err;
    logic [15:0] loaded_at_done;
    logic [15:0] exp_loaded = 16'd0;
    logic        exp_hold   = 1'b0;

    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            got_q.push_back({wb_address, wb_data});
            got_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            loaded_at_done = loaded_words;
        end
        if (error === 1'b1) err_cnt++;
    end

    task automatic clear_obs();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        acc_cyc_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        exp_done = 0;
        exp_err  = 0;
    endtask

    // ---------------- reference model ----------------
    // Interprets a byte stream at frame level: skip to MAGIC, read LEN, take 4*LEN bytes
    // as little-endian words written from BASE_WORD upward, then (optionally) verify the sum.
    function automatic void model_stream(input logic [7:0] s[$]);
        int i = 0;
        int len;
        int j;
        logic [7:0] sum;
        while (i < s.size() && s[i] != MAGIC) i++;
        if (i + 2 >= s.size()) return;
        len = int'({s[i+2], s[i+1]});
        if (len > int'(MAX_WORDS)) begin
            exp_err++;
            exp_hold = 1'b1;
            return;
        end
        for (int k = 0; k < len; k++) begin
            j = i + 3 + 4 * k;
            if (j + 3 >= s.size()) return;
            exp_q.push_back({32'(BASE_WORD + k), s[j+3], s[j+2], s[j+1], s[j]});
        end
`ifdef IMEM_LOADER_CSUM_EN
        j = i + 3 + 4 * len;
        if (j >= s.size()) return;
        sum = 8'h00;
        for (int t = i + 1; t <= j; t++) sum = sum + s[t];
        if (sum != 8'h00) begin
            exp_err++;
            exp_hold = 1'b1;
            return;
        end
`else
        sum = 8'h00;
        if (i + 3 + 4 * len > s.size()) return;
`endif
        exp_done++;
        exp_hold   = 1'b0;
        exp_loaded = 16'(len);
    endfunction

    function automatic void build_frame(input int len, input bit garbage, output logic [7:0] f[$]);
        logic [7:0]  sum;
        logic [7:0]  g;
        logic [15:0] l;
        logic [31:0] w;
        f.delete();
        if (garbage) begin
            for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
                do g = 8'($urandom); while (g == MAGIC);
                f.push_back(g);
            end
        end
        l = 16'(len);
        f.push_back(MAGIC);
        f.push_back(l[7:0]);
        f.push_back(l[15:8]);
        sum = l[7:0] + l[15:8];
        for (int k = 0; k < len; k++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                f.push_back(w[8*b +: 8]);
                sum = sum + w[8*b +: 8];
            end
        end
`ifdef IMEM_LOADER_CSUM_EN
        f.push_back(8'h00 - sum);
`endif
    endfunction

    // ---------------- drivers ----------------
    // Entered and left on a falling edge; holds the byte until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int tries = 0;
        int gap   = int'($urandom_range(max_gap, 0));
        for (int k = 0; k < gap; k++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        n_checks++;
        if (tries >= 20) begin
            n_fail++;
            $display("FAIL rx_ready_stall: rx_ready=%b after %0d cycles, required 1", rx_ready, tries);
        end
        acc_cyc_q.push_back(cyc + 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[k]) send_byte(s[k], max_gap);
    endtask

    task automatic drain();
        repeat (10) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_hold   = 1'b0;
        exp_loaded = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_ready, wb_en, cpu_hold, done, error} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: {rdy,wb_en,hold,done,err}=%b required 10000",
                     {rx_ready, wb_en, cpu_hold, done, error});
        end
        n_checks++;
        if (wb_address !== 32'd0 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wb: addr=%h data=%h required 0/0", wb_address, wb_data);
        end
        n_checks++;
        if (loaded_words !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_loaded: loaded_words=%0d required 0", loaded_words);
        end
        apply_reset();
        n_checks++;
        if ({rx_ready, wb_en, cpu_hold, done, error} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_release: {rdy,wb_en,hold,done,err}=%b required 10000",
                     {rx_ready, wb_en, cpu_hold, done, error});
        end
    endtask

    task automatic test_single();
        logic [7:0] f[$];
        clear_obs();
        f = {MAGIC, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
        f.push_back(8'hE7);
`endif
        send_byte(f[0], 0);
        n_checks++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold_on: cpu_hold=%b required 1", cpu_hold);
        end
        for (int k = 1; k < f.size(); k++) send_byte(f[k], 0);
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'(BASE_WORD), 32'h00000513}) begin
            n_fail++;
            $display("FAIL single_write: count=%0d first=%h required 1 x %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 64'h0, {32'(BASE_WORD), 32'h00000513});
        end
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0 || loaded_at_done !== 16'd1) begin
            n_fail++;
            $display("FAIL single_done: done=%0d err=%0d loaded=%0d required 1/0/1",
                     done_cnt, err_cnt, loaded_at_done);
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || loaded_words !== 16'd1) begin
            n_fail++;
            $display("FAIL single_hold_off: cpu_hold=%b loaded=%0d required 0/1", cpu_hold, loaded_words);
        end
        exp_hold   = 1'b0;
        exp_loaded = 16'd1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] f[$];
        int lenhi_cyc;
        clear_obs();
        build_frame(3, 1'b0, f);
        model_stream(f);
        send_stream(f, 0);
        drain();
        lenhi_cyc = acc_cyc_q[2];
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: writes=%0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL b2b_write[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
                end
                n_checks++;
                if (got_cyc_q[k] != lenhi_cyc + 4 * (k + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_timing[%0d]: wb_en at %0d cycles after LEN_HI, required %0d",
                             k, got_cyc_q[k] - lenhi_cyc, 4 * (k + 1));
                end
            end
        end
        n_checks++;
        if (done_cnt != exp_done || loaded_words !== exp_loaded) begin
            n_fail++;
            $display("FAIL b2b_done: done=%0d loaded=%0d required %0d/%0d",
                     done_cnt, loaded_words, exp_done, exp_loaded);
        end
    endtask

    task automatic test_oversize();
        logic [7:0] f[$];
        clear_obs();
        f = {MAGIC, 8'h16, 8'h00};
        model_stream(f);
        send_stream(f, 0);
        drain();
        n_checks++;
        if (err_cnt != 1 || done_cnt != 0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL oversize_reject: err=%0d done=%0d writes=%0d required 1/0/0",
                     err_cnt, done_cnt, got_q.size());
        end
        n_checks++;
        if (cpu_hold !== 1'b1 || exp_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize_hold: cpu_hold=%b required 1", cpu_hold);
        end
        clear_obs();
        build_frame(2, 1'b0, f);
        model_stream(f);
        send_stream(f, 1);
        drain();
        n_checks++;
        if (cpu_hold !== exp_hold || done_cnt != exp_done || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL oversize_recover: hold=%b done=%0d writes=%0d required %b/%0d/%0d",
                     cpu_hold, done_cnt, got_q.size(), exp_hold, exp_done, exp_q.size());
        end
    endtask

    task automatic test_garbage_gaps();
        logic [7:0] f[$];
        clear_obs();
        f = {8'h00, 8'hFF, 8'h12, MAGIC, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
        f.push_back(8'hE7);
`endif
        for (int k = 0; k < 6; k++) send_byte(f[k], 0);
        for (int k = 6; k < f.size(); k++) send_byte(f[k], 5);
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'(BASE_WORD), 32'h00000513}) begin
            n_fail++;
            $display("FAIL garbage_write: count=%0d first=%h required 1 x %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 64'h0, {32'(BASE_WORD), 32'h00000513});
        end
        n_checks++;
        if (done_cnt != 1 || loaded_words !== 16'd1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL garbage_done: done=%0d loaded=%0d hold=%b required 1/1/0",
                     done_cnt, loaded_words, cpu_hold);
        end
        exp_hold   = 1'b0;
        exp_loaded = 16'd1;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] f[$];
        logic [7:0] part[$];
        clear_obs();
        build_frame(3, 1'b0, f);
        for (int k = 0; k < 9; k++) part.push_back(f[k]);
        model_stream(part);
        send_stream(part, 0);
        rst = 1'b0;
        exp_hold   = 1'b0;
        exp_loaded = 16'd0;
        @(negedge clk);
        n_checks++;
        if ({rx_ready, wb_en, cpu_hold, done, error} !== 5'b10000 || wb_address !== 32'd0 ||
            wb_data !== 32'd0 || loaded_words !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_values: flags=%b addr=%h data=%h loaded=%0d required 10000/0/0/0",
                     {rx_ready, wb_en, cpu_hold, done, error}, wb_address, wb_data, loaded_words);
        end
        @(negedge clk);
        rst = 1'b1;
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL midreset_writes: writes=%0d required %0d", got_q.size(), exp_q.size());
        end
        n_checks++;
        if (done_cnt != 0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: done=%0d hold=%b required 0/0", done_cnt, cpu_hold);
        end
        clear_obs();
        build_frame(3, 1'b0, f);
        model_stream(f);
        send_stream(f, 2);
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size() || done_cnt != 1 || loaded_words !== 16'd3) begin
            n_fail++;
            $display("FAIL midreset_reload: writes=%0d done=%0d loaded=%0d required %0d/1/3",
                     got_q.size(), done_cnt, loaded_words, exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL midreset_reload[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum_bad();
        logic [7:0] f[$];
        clear_obs();
        f = {MAGIC, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hE6};
        model_stream(f);
        send_stream(f, 0);
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {32'(BASE_WORD), 32'h00000513}) begin
            n_fail++;
            $display("FAIL csum_bad_write: writes=%0d required 1", got_q.size());
        end
        n_checks++;
        if (err_cnt != 1 || done_cnt != 0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL csum_bad_reject: err=%0d done=%0d hold=%b required 1/0/1",
                     err_cnt, done_cnt, cpu_hold);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] f[$];
        int len;
        for (int n = 0; n < 10; n++) begin
            clear_obs();
            case (n)
                0:       len = 0;
                1:       len = int'(MAX_WORDS);
                default: len = int'($urandom_range(MAX_WORDS, 1));
            endcase
            build_frame(len, n[0], f);
            model_stream(f);
            send_stream(f, 3);
            drain();
            n_checks++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d_count: writes=%0d required %0d", n, got_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) begin
                if (k < got_q.size()) begin
                    n_checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        n_fail++;
                        $display("FAIL random%0d_write[%0d]: got %h required %h", n, k, got_q[k], exp_q[k]);
                    end
                end
            end
            n_checks++;
            if (done_cnt != exp_done || err_cnt != exp_err || loaded_words !== exp_loaded ||
                cpu_hold !== exp_hold) begin
                n_fail++;
                $display("FAIL random%0d_status: done=%0d err=%0d loaded=%0d hold=%b required %0d/%0d/%0d/%b",
                         n, done_cnt, err_cnt, loaded_words, cpu_hold, exp_done, exp_err, exp_loaded, exp_hold);
            end
            if (exp_done > 0) begin
                n_checks++;
                if (loaded_at_done !== exp_loaded) begin
                    n_fail++;
                    $display("FAIL random%0d_loaded_at_done: %0d required %0d", n, loaded_at_done, exp_loaded);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_oversize();
        test_garbage_gaps();
        test_reset_midframe();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum_bad();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
